// File: rtl/m3_ramp_ctrl.sv
// m3_ramp_ctrl: soft-start/soft-stop sequencer with reversal dead time and force-stop bypass
module m3_ramp_ctrl #(
  parameter int FREQ_W   = 10,
  parameter int STEP_DIV = 10000,
  parameter int FREQ_MIN = 10,
  parameter int DEAD_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmdRun,
  input  logic              cmdForceStop,
  input  logic              cmdInvRotate,
  input  logic [FREQ_W-1:0] cmdFreq,
  output logic              m3start,
  output logic              m3forceStop,
  output logic              m3invRotate,
  output logic [FREQ_W-1:0] m3freq,
  output logic              busy,
  output logic [2:0]        state
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, RAMP = 3'd1, RUN = 3'd2, STOPPING = 3'd3, COAST = 3'd4, FSTOP = 3'd5
  } state_t;
  localparam int PW = $clog2(STEP_DIV);
  localparam int CW = $clog2(DEAD_CYC + 1);
  localparam logic [FREQ_W-1:0] FMIN = FREQ_W'(FREQ_MIN);
  state_t cur, nxt;
  logic [PW-1:0] presc, prescN;
  logic [CW-1:0] coast, coastN;
  logic [FREQ_W-1:0] freqN;
  logic startN, fsN, invN, stopReq, tick;
  assign state = cur;
  assign stopReq = !cmdRun || cmdFreq == '0 || cmdInvRotate != m3invRotate;
  assign tick = presc == PW'(STEP_DIV - 1);
  always_comb begin
    nxt = cur;
    freqN = m3freq;
    startN = m3start;
    fsN = 1'b0;
    invN = m3invRotate;
    prescN = '0;
    coastN = '0;
    if (cmdForceStop) begin
      nxt = FSTOP;
      freqN = '0;
      startN = 1'b0;
      fsN = 1'b1;
    end else begin
      case (cur)
        IDLE: begin
          freqN = '0;
          startN = 1'b0;
          if (cmdRun && cmdFreq != '0) begin
            nxt = RAMP;
            freqN = cmdFreq < FMIN ? cmdFreq : FMIN;
            startN = 1'b1;
            invN = cmdInvRotate;
          end
        end
        RAMP: begin
          if (stopReq) nxt = STOPPING;
          else if (m3freq == cmdFreq) nxt = RUN;
          else begin
            prescN = tick ? '0 : presc + 1'b1;
            if (tick) freqN = m3freq < cmdFreq ? m3freq + 1'b1 : m3freq - 1'b1;
          end
        end
        RUN: nxt = stopReq ? STOPPING : (cmdFreq != m3freq ? RAMP : RUN);
        STOPPING: begin
          // the edge that lands on zero also drops start and enters COAST
          if (m3freq == '0 || (tick && m3freq == FREQ_W'(1))) begin
            nxt = COAST;
            freqN = '0;
            startN = 1'b0;
          end else begin
            prescN = tick ? '0 : presc + 1'b1;
            if (tick) freqN = m3freq - 1'b1;
          end
        end
        COAST: begin
          freqN = '0;
          startN = 1'b0;
          nxt = coast == CW'(DEAD_CYC - 1) ? IDLE : COAST;
          coastN = coast == CW'(DEAD_CYC - 1) ? '0 : coast + 1'b1;
        end
        FSTOP: begin
          nxt = COAST;
          freqN = '0;
          startN = 1'b0;
        end
        default: begin
          nxt = IDLE;
          freqN = '0;
          startN = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= IDLE;
      m3freq <= '0;
      m3start <= 1'b0;
      m3forceStop <= 1'b0;
      m3invRotate <= 1'b0;
      busy <= 1'b0;
      presc <= '0;
      coast <= '0;
    end else begin
      cur <= nxt;
      m3freq <= freqN;
      m3start <= startN;
      m3forceStop <= fsN;
      m3invRotate <= invN;
      busy <= nxt != IDLE;
      presc <= prescN;
      coast <= coastN;
    end
  end
endmodule

// File: tb/tb_m3_ramp_ctrl.sv
// tb_m3_ramp_ctrl: scoreboard bench; a cycle-level reference model queues expected outputs per edge
module tb_m3_ramp_ctrl;
  localparam int SD = 4, FM = 10, DC = 8;
  logic clk = 0, rstv = 1;
  logic run = 0, fstop = 0, inv = 0;
  logic [9:0] freq = '0;
  logic m3start, m3forceStop, m3invRotate, busy;
  logic [9:0] m3freq;
  logic [2:0] state;
  int checks = 0, errors = 0;
  int ms = 0, mf = 0, age = 0;
  bit mstart = 0, mfs = 0, minv = 0;
  logic [16:0] q[$];
  bit prevStart = 0, prevInv = 0;

  m3_ramp_ctrl #(.FREQ_W(10), .STEP_DIV(SD), .FREQ_MIN(FM), .DEAD_CYC(DC)) dut (
    .clk(clk), .rst(rstv), .cmdRun(run), .cmdForceStop(fstop), .cmdInvRotate(inv),
    .cmdFreq(freq), .m3start(m3start), .m3forceStop(m3forceStop), .m3invRotate(m3invRotate),
    .m3freq(m3freq), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] outs();
    return {m3start, m3forceStop, m3invRotate, m3freq, busy, state};
  endfunction

  // reference: states by code, steps fall on every SD-th edge spent in a state
  task automatic modelStep();
    int ns, f;
    bit stopc, stepEdge;
    f = int'(freq);
    if (rstv) begin
      ms = 0; mf = 0; mstart = 0; mfs = 0; minv = 0; age = 0;
    end else begin
      stopc = !run || f == 0 || inv != minv;
      stepEdge = (age + 1) % SD == 0;
      ns = ms;
      mfs = 0;
      if (fstop) begin
        ns = 5; mf = 0; mstart = 0; mfs = 1;
      end else if (ms == 0) begin
        if (run && f != 0) begin
          ns = 1; mf = f < FM ? f : FM; mstart = 1; minv = inv;
        end
      end else if (ms == 1) begin
        if (stopc) ns = 3;
        else if (mf == f) ns = 2;
        else if (stepEdge) mf = mf + (f > mf ? 1 : -1);
      end else if (ms == 2) begin
        if (stopc) ns = 3;
        else if (mf != f) ns = 1;
      end else if (ms == 3) begin
        if (stepEdge && mf > 0) mf = mf - 1;
        if (mf == 0) begin
          ns = 4; mstart = 0;
        end
      end else if (ms == 4) begin
        if (age + 1 == DC) ns = 0;
      end else ns = 4;
      age = ns == ms ? age + 1 : 0;
      ms = ns;
    end
    q.push_back({mstart, mfs, minv, 10'(mf), ms != 0, 3'(ms)});
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      modelStep();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic waitModel(int code, int fv, int maxc, string nm);
    int i;
    for (i = 0; i < maxc && !(ms == code && (fv < 0 || mf == fv)); i++) cyc(1);
    if (!(ms == code && (fv < 0 || mf == fv))) begin
      errors++;
      $display("FAIL %s timeout: state=%0d freq=%0d wanted state=%0d freq=%0d", nm, ms, mf, code, fv);
    end
  endtask

  always @(posedge clk) begin
    logic [16:0] e, a;
    #1;
    a = outs();
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got start=%0b fs=%0b inv=%0b freq=%0d busy=%0b state=%0d, want start=%0b fs=%0b inv=%0b freq=%0d busy=%0b state=%0d",
                 $time, a[16], a[15], a[14], a[13:4], a[3], a[2:0], e[16], e[15], e[14], e[13:4], e[3], e[2:0]);
      end
    end
    if (prevStart && m3start) begin
      checks++;
      if (m3invRotate !== prevInv) begin
        errors++;
        $display("FAIL invHold @%0t: inv=%0b want %0b while running", $time, m3invRotate, prevInv);
      end
    end
    prevStart = m3start;
    prevInv = m3invRotate;
  end

  initial begin
    @(negedge clk);
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL resetState: got %h want 0", outs());
    end
    cyc(3);
    rstv = 0; run = 1; freq = 20; inv = 0;
    waitModel(2, 20, 100, "rampUp");
    cyc(3);
    inv = 1;
    waitModel(0, -1, 200, "reverse");
    waitModel(2, 20, 100, "restartRev");
    cyc(2);
    freq = 15;
    waitModel(2, 15, 100, "retarget");
    cyc(2);
    freq = 20;
    waitModel(2, 20, 100, "backTo20");
    freq = 10;
    waitModel(1, 14, 100, "downTo14");
    fstop = 1;
    cyc(5);
    fstop = 0;
    waitModel(0, -1, 50, "fstopCoast");
    waitModel(2, 10, 20, "restart10");
    freq = 20;
    waitModel(2, 20, 100, "upAgain");
    inv = 0;
    waitModel(3, 7, 200, "stopTo7");
    #2 rstv = 1;
    #1;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL asyncReset: got %h want 0", outs());
    end
    @(negedge clk);
    cyc(2);
    rstv = 0; run = 1; freq = 5; inv = 0;
    waitModel(2, 5, 20, "lowStart");
    cyc(3);
    for (int i = 0; i < 1500; i++) begin
      rstv = $urandom_range(0, 199) == 0;
      fstop = $urandom_range(0, 99) < 2;
      run = $urandom_range(0, 99) < 92;
      if ($urandom_range(0, 99) < 2) inv = ~inv;
      if ($urandom_range(0, 99) < 4) freq = 10'($urandom_range(0, 25));
      cyc(1);
    end
    rstv = 0; fstop = 0;
    cyc(2);
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
